// File: rtl/apb_master_bridge.sv
// Single-outstanding command-to-APB master: IDLE -> SETUP -> ACCESS -> RESP.
// Every APB and rsp_* output is a flop; a wait counter aborts hung ACCESS phases.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t     r_state, w_next;
  logic [7:0] r_wait_cnt;
  logic       w_accept, w_done, w_abort;

  assign w_accept = cmd_valid & cmd_ready;
  assign w_done   = (r_state == S_ACCESS) & PREADY;
  // PREADY on the TIMEOUT cycle completes normally rather than aborting
  assign w_abort  = (r_state == S_ACCESS) & ~PREADY & (r_wait_cnt == TO_CNT);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)          w_next = S_SETUP;
      S_SETUP:                         w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_next = S_RESP;
      S_RESP:   if (rsp_ready)         w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flops yet line up with it
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cmd_ready   <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      r_wait_cnt  <= 8'd0;
    end else begin
      cmd_ready <= (w_next == S_IDLE);
      PSEL      <= (w_next == S_SETUP) || (w_next == S_ACCESS);
      PENABLE   <= (w_next == S_ACCESS);
      rsp_valid <= (w_next == S_RESP);

      if (r_state == S_SETUP)       r_wait_cnt <= 8'd1;
      else if (r_state == S_ACCESS) r_wait_cnt <= r_wait_cnt + 8'd1;

      if (w_accept) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_write ? cmd_wdata : '0;
        PSTRB  <= cmd_write ? cmd_strb  : '0;
      end

      if (w_done) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: memory slave with per-command wait states,
// directed vector table, reset-abort sequence and randomized commands vs a model.
module tb_apb_master_bridge;
  localparam int AW = 10, DW = 32, SW = 4, TO = 16;

  logic          PCLK = 1'b0, PRESETn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [SW-1:0] PSTRB;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // Memory slave: PREADY on ACCESS cycle number slv_lat (0 = never), 0x111 errors
  logic [DW-1:0] mem     [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  int slv_lat = 1;
  int acc_cnt;

  function automatic logic [DW-1:0] seed(int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  assign PREADY  = PSEL && PENABLE && (slv_lat != 0) && (acc_cnt + 1 == slv_lat);
  assign PRDATA  = mem[PADDR];
  assign PSLVERR = (PADDR == 10'h111);

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      acc_cnt <= 0;
      for (int i = 0; i < (1 << AW); i++) mem[i] <= seed(i);
    end else begin
      if (PSEL && PENABLE) acc_cnt <= PREADY ? 0 : acc_cnt + 1;
      else                 acc_cnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR)
        for (int b = 0; b < SW; b++)
          if (PSTRB[b]) mem[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

  typedef struct {
    logic [AW-1:0] addr; logic wr; logic [DW-1:0] wd; logic [SW-1:0] st; int lat; int rdly;
  } cmd_t;
  typedef struct { logic [DW-1:0] rd; logic err; logic to; int lat; } exp_t;
  typedef struct { cmd_t c; exp_t e; } vec_t;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void reseed_ref();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = seed(i);
  endfunction

  // Reference: ACCESS length min(lat, TIMEOUT); latency counted from the accept cycle
  function automatic exp_t model(cmd_t c);
    exp_t e;
    e.to  = (c.lat == 0) || (c.lat > TO);
    e.err = e.to || (c.addr == 10'h111);
    e.lat = 2 + (e.to ? TO : c.lat);
    e.rd  = (c.wr || e.to) ? '0 : ref_mem[c.addr];
    if (c.wr && !e.err)
      for (int b = 0; b < SW; b++)
        if (c.st[b]) ref_mem[c.addr][8*b +: 8] = c.wd[8*b +: 8];
    return e;
  endfunction

  task automatic run_cmd(input cmd_t c, input exp_t e, input string tag);
    int cyc, nacc, hold_bad;
    logic [SW-1:0] xs;
    logic [DW-1:0] xd;
    xs = c.wr ? c.st : '0;
    xd = c.wr ? c.wd : '0;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin @(negedge PCLK); cyc++; end
    check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    slv_lat   = c.lat;
    cmd_valid = 1'b1; cmd_addr = c.addr; cmd_write = c.wr; cmd_wdata = c.wd; cmd_strb = c.st;
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_write = 1'($urandom);
    cmd_wdata = $urandom; cmd_strb = SW'($urandom);
    check({tag, ".setup_ctl"}, {PSEL, PENABLE, PWRITE, cmd_ready}, {2'b10, c.wr, 1'b0});
    check({tag, ".setup_addr"}, 64'(PADDR), 64'(c.addr));
    check({tag, ".setup_data"}, {PSTRB, PWDATA}, {xs, xd});
    cyc = 1; nacc = 0; hold_bad = 0;
    while (!rsp_valid && cyc < 60) begin
      @(negedge PCLK); cyc++;
      if (PSEL && PENABLE) begin
        nacc++;
        if (PADDR !== c.addr || PWRITE !== c.wr || PSTRB !== xs || PWDATA !== xd || cmd_ready !== 1'b0)
          hold_bad++;
      end
    end
    check({tag, ".latency"}, 64'(cyc), 64'(e.lat));
    check({tag, ".access_cycles"}, 64'(nacc), 64'(e.lat - 2));
    check({tag, ".access_hold_errs"}, 64'(hold_bad), 64'd0);
    check({tag, ".rsp"}, {PSEL, PENABLE, rsp_err, rsp_timeout, rsp_rdata},
          {2'b00, e.err, e.to, e.rd});
    for (int i = 0; i < c.rdly; i++) begin
      cmd_valid = 1'b1; cmd_addr = AW'($urandom); cmd_write = 1'($urandom);
      @(negedge PCLK);
      check({tag, ".stall"}, {rsp_valid, rsp_err, rsp_timeout, cmd_ready, PSEL, rsp_rdata},
            {1'b1, e.err, e.to, 1'b0, 1'b0, e.rd});
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check({tag, ".after_hs"}, {rsp_valid, cmd_ready, PSEL}, 3'b010);
  endtask

  vec_t tbl [9];

  initial begin
    cmd_t c;
    exp_t e;
    tbl[0] = '{'{10'h004, 1'b1, 32'hDEADBEEF, 4'hF, 4,  0}, '{32'h0,        1'b0, 1'b0, 6}};
    tbl[1] = '{'{10'h004, 1'b0, 32'h12345678, 4'hF, 2,  0}, '{32'hDEADBEEF, 1'b0, 1'b0, 4}};
    tbl[2] = '{'{10'h111, 1'b1, 32'h00000001, 4'hF, 1,  0}, '{32'h0,        1'b1, 1'b0, 3}};
    tbl[3] = '{'{10'h008, 1'b0, 32'h0,        4'hF, 0,  0}, '{32'h0,        1'b1, 1'b1, 18}};
    tbl[4] = '{'{10'h004, 1'b0, 32'h0,        4'h0, 1,  5}, '{32'hDEADBEEF, 1'b0, 1'b0, 3}};
    tbl[5] = '{'{10'h004, 1'b1, 32'h11223344, 4'h5, 17, 0}, '{32'h0,        1'b1, 1'b1, 18}};
    tbl[6] = '{'{10'h004, 1'b0, 32'h0,        4'hA, 16, 1}, '{32'hDEADBEEF, 1'b0, 1'b0, 18}};
    tbl[7] = '{'{10'h004, 1'b1, 32'h11223344, 4'h5, 3,  0}, '{32'h0,        1'b0, 1'b0, 5}};
    tbl[8] = '{'{10'h004, 1'b0, 32'h0,        4'hF, 1,  2}, '{32'hDE22BE44, 1'b0, 1'b0, 3}};

    reseed_ref();
    @(negedge PCLK);
    check("reset_ctl", {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}, 7'd0);
    check("reset_data", {PADDR, PSTRB, PWDATA}, '0);
    check("reset_rdata", 64'(rsp_rdata), 64'd0);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    check("post_reset_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 9; i++) begin
      e = model(tbl[i].c);
      run_cmd(tbl[i].c, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a hung write: bus drops at once, no response
    slv_lat = 0;
    cmd_valid = 1'b1; cmd_addr = 10'h005; cmd_write = 1'b1; cmd_wdata = 32'hCAFEF00D; cmd_strb = 4'hF;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    check("rst.in_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1 check("rst.immediate", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0000);
    reseed_ref();
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("rst.no_rsp", {rsp_valid, PSEL, PENABLE, cmd_ready}, 4'b0001);
    end
    c = '{10'h005, 1'b0, 32'h0, 4'hF, 1, 0};
    e = model(c);
    run_cmd(c, e, "rst.read");

    for (int k = 0; k < 40; k++) begin
      c.addr = ($urandom_range(0, 9) == 0) ? 10'h111 : AW'($urandom_range(0, 7));
      c.wr   = 1'($urandom);
      c.wd   = $urandom;
      c.st   = SW'($urandom);
      case ($urandom_range(0, 9))
        0:       c.lat = 0;
        1:       c.lat = TO;
        2:       c.lat = TO + 1;
        default: c.lat = int'($urandom_range(1, 5));
      endcase
      c.rdly = int'($urandom_range(0, 3));
      e = model(c);
      run_cmd(c, e, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
